dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter AW, default 12, RAM word-address width.
REQ-002 Parameter DW, default 32, data width; the byte-enable width is DW/8.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive DMA grants while locked; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  CPU access request, level, valid every cycle.
REQ-007 cpu_we  input  DW/8  CPU byte write enables; all-zero means read.
REQ-008 cpu_addr  input  AW  CPU word address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_gnt  output  1  CPU access issued to RAM this cycle.
REQ-011 cpu_stall  output  1  pipeline hold: cpu_req and not cpu_gnt.
REQ-012 cpu_rvalid  output  1  read data for the CPU's previous-cycle read is on rdata.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata  input  1/DW/8/AW/DW  DMA requester, same meaning as the CPU fields.
REQ-014 dma_lock  input  1  DMA requests back-to-back ownership (burst).
REQ-015 dma_gnt  output  1  DMA access issued to RAM this cycle.
REQ-016 dma_rvalid  output  1  read data for the DMA's previous-cycle read is on rdata.
REQ-017 rdata  output  DW  registered copy of ram_dout, shared by both requesters.
REQ-018 ram_en, ram_we, ram_addr, ram_din  output  1/DW/8/AW/DW  block-RAM port A controls.
REQ-019 ram_dout  input  DW  block-RAM read data, valid one cycle after the address.

Function
REQ-020 Arbitration is combinational within the cycle: at most one of cpu_gnt and dma_gnt is high in any cycle.
REQ-021 A grant requires the matching req; when neither requester is requesting, ram_en=0 and ram_we=0.
REQ-022 A granted requester's we, addr and wdata are muxed to ram_we, ram_addr and ram_din in the same cycle, with ram_en=1.
REQ-023 Read latency is 2 cycles from grant: RAM output at grant+1, then rdata registered at grant+2, with the matching rvalid high for exactly one cycle.
REQ-024 rvalid is only raised for grants whose we was all-zero; writes produce no rvalid.
REQ-025 When both requesters are requesting and no lock is active, priority follows REQ-040/041.
REQ-026 Lock: if DMA is granted with dma_lock=1, the DMA keeps priority over the CPU on following cycles while dma_req and dma_lock stay high.
REQ-027 burst_cnt counts consecutive locked DMA grants.
REQ-028 When burst_cnt reaches MAX_BURST and cpu_req=1, the CPU is granted for exactly one cycle and burst_cnt clears. The DMA then regains ownership if it is still locked.
REQ-029 When burst_cnt reaches MAX_BURST and cpu_req=0, the DMA continues and burst_cnt saturates at MAX_BURST.
REQ-030 Dropping dma_req or dma_lock releases the lock immediately and clears burst_cnt on the next edge.
REQ-031 State machine: IDLE (no owner), OWN_CPU, OWN_DMA, DMA_LOCKED.
REQ-032 Transitions to the owner granted this cycle; with no grant, the next state is IDLE.
REQ-033 DMA_LOCKED is entered on a DMA grant with dma_lock=1.
REQ-034 DMA_LOCKED is left by the forced CPU slot (to OWN_CPU) or by lock release.
REQ-035 last_owner (1 bit) updates on every grant and holds when idle.

Reset
REQ-036 While rst_n=0: state=IDLE, burst_cnt=0, last_owner=DMA.
REQ-037 While rst_n=0, all outputs are 0, including rdata.
REQ-038 Reset mid-burst or with a read in flight discards the pending rvalid; no rvalid is raised after release.
REQ-039 The first cycle after rst_n rises arbitrates normally.

Configuration
REQ-040 Macro DMEM_ARB_RR_EN defined: on contention without a lock, the requester that is not last_owner wins (round-robin).
REQ-041 Macro DMEM_ARB_RR_EN undefined: on contention without a lock, the CPU always wins (fixed priority). last_owner is unused, and the lock and forced-slot rules are unchanged.

Verification
REQ-042 Idle, then cpu_req=1, we=0, addr=0x010, with RAM[0x010]=0xDEADBEEF -> cpu_gnt the same cycle, cpu_stall=0, cpu_rvalid with rdata=0xDEADBEEF 2 cycles later.
REQ-043 Both requesting continuously, unlocked, RR build -> grants alternate CPU, DMA, CPU, ...; fixed build -> CPU every cycle with dma_gnt=0.
REQ-044 dma_lock=1 and dma_req=1 for 20 cycles, cpu_req=1 throughout, MAX_BURST=8 -> 8 DMA grants, 1 CPU grant, 8 DMA grants, 1 CPU grant, remaining DMA; cpu_stall is high on every non-CPU cycle.
REQ-045 DMA write with we=0x3, addr=0x004, wdata=0x12345678, then a CPU read of 0x004 over initial 0xAAAAAAAA -> cpu rdata=0xAAAA5678; no dma_rvalid after the write.
REQ-046 rst_n pulsed low for 1 cycle right after a CPU read grant -> all outputs 0 asynchronously, no cpu_rvalid afterwards, and the next grant goes to the CPU under contention.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_port_arbiter
// Purpose : Arbitrates one block-RAM port (port A) between a CPU requester and
//           a DMA requester. The grant is combinational within the cycle. Read
//           data comes back through one shared output register two cycles
//           after the grant.
//           A locked DMA burst keeps ownership of the port. After MAX_BURST
//           consecutive locked DMA grants, a waiting CPU gets one forced slot.
// Config  : DMEM_ARB_RR_EN defined   -> round-robin on unlocked contention
//           DMEM_ARB_RR_EN undefined -> CPU has fixed priority
// Ports   : clk, rst_n (async, active-low)
//           cpu_req/we/addr/wdata -> cpu_gnt, cpu_stall, cpu_rvalid
//           dma_req/we/addr/wdata/lock -> dma_gnt, dma_rvalid
//           rdata                  : registered ram_dout, shared
//           ram_en/we/addr/din     : RAM port controls, ram_dout : RAM data
// Rev     : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic [DW/8-1:0] cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_stall,
  output logic            cpu_rvalid,
  input  logic            dma_req,
  input  logic [DW/8-1:0] dma_we,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  input  logic            dma_lock,
  output logic            dma_gnt,
  output logic            dma_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  localparam int            CW        = 8;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_OWN_CPU    = 2'd1;
  localparam logic [1:0] ST_OWN_DMA    = 2'd2;
  localparam logic [1:0] ST_DMA_LOCKED = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic          resume;        // last cycle was the forced CPU slot of a burst
  logic          lock_active;
  logic          forced_slot;
  logic          cpu_win, dma_win;
  logic          cpu_rd_q, dma_rd_q;
`ifdef DMEM_ARB_RR_EN
  logic          last_owner;    // 1 = DMA, 0 = CPU
`endif

  // The burst owns the port while DMA keeps lock asserted. The cycle after
  // the forced CPU slot still counts as locked, so DMA regains the port.
  assign lock_active = dma_req && dma_lock && ((state == ST_DMA_LOCKED) || resume);
  assign forced_slot = lock_active && cpu_req && (burst_cnt == BURST_MAX);

  // ---------------- arbitration (pure function of this cycle) -------------
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (lock_active) begin
      if (forced_slot) cpu_win = 1'b1;
      else             dma_win = 1'b1;
    end else if (cpu_req && dma_req) begin
`ifdef DMEM_ARB_RR_EN
      if (last_owner) cpu_win = 1'b1;
      else            dma_win = 1'b1;
`else
      cpu_win = 1'b1;
`endif
    end else begin
      cpu_win = cpu_req;
      dma_win = dma_req;
    end
  end

  // ---------------- state register ----------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      resume    <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      resume    <= forced_slot;
    end
  end

  // ---------------- next-state logic --------------------------------------
  always_comb begin
    state_nxt = ST_IDLE;
    if (cpu_win)                  state_nxt = ST_OWN_CPU;
    else if (dma_win && dma_lock) state_nxt = ST_DMA_LOCKED;
    else if (dma_win)             state_nxt = ST_OWN_DMA;

    burst_cnt_nxt = burst_cnt;
    if (!(dma_req && dma_lock) || forced_slot)
      burst_cnt_nxt = '0;
    else if (dma_win && burst_cnt != BURST_MAX)
      burst_cnt_nxt = burst_cnt + 1'b1;   // saturates at BURST_MAX
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_owner <= 1'b1;
    else if (cpu_win) last_owner <= 1'b0;
    else if (dma_win) last_owner <= 1'b1;
  end
`endif

  // ---------------- output logic ------------------------------------------
  // Outputs are forced low while reset is asserted, even with requests present.
  always_comb begin
    cpu_gnt   = rst_n && cpu_win;
    dma_gnt   = rst_n && dma_win;
    cpu_stall = rst_n && cpu_req && !cpu_win;
    ram_en    = cpu_gnt || dma_gnt;
    ram_we    = '0;
    ram_addr  = '0;
    ram_din   = '0;
    if (cpu_gnt) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end else if (dma_gnt) begin
      ram_we   = dma_we;
      ram_addr = dma_addr;
      ram_din  = dma_wdata;
    end
  end

  // ---------------- read-return pipeline ----------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_q   <= 1'b0;
      dma_rd_q   <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      rdata      <= '0;
    end else begin
      cpu_rd_q   <= cpu_win && (cpu_we == '0);
      dma_rd_q   <= dma_win && (dma_we == '0);
      cpu_rvalid <= cpu_rd_q;
      dma_rvalid <= dma_rd_q;
      rdata      <= ram_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Purpose : Self-checking bench for dmem_port_arbiter with a byte-write
//           block-RAM model. Works in both the fixed-priority build and the
//           DMEM_ARB_RR_EN build.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, dma_req, dma_lock;
  logic [3:0]  cpu_we, dma_we;
  logic [11:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(12), .DW(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Read-first block RAM with byte enables, one-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
    end
  end

  typedef struct {
    logic        cr;  logic [3:0] cwe; logic [11:0] ca;
    logic        dr;  logic [3:0] dwe; logic [11:0] da; logic [31:0] dwd; logic dl;
    logic        ecg, edg, est, ecv, edv;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(logic cr, logic [3:0] cwe, logic [11:0] ca,
                              logic dr, logic [3:0] dwe, logic [11:0] da,
                              logic [31:0] dwd, logic dl,
                              logic ecg, logic edg, logic est, logic ecv,
                              logic edv, logic [31:0] erd);
    vec_t v;
    v.cr = cr; v.cwe = cwe; v.ca = ca; v.dr = dr; v.dwe = dwe; v.da = da;
    v.dwd = dwd; v.dl = dl; v.ecg = ecg; v.edg = edg; v.est = est;
    v.ecv = ecv; v.edv = edv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic cr, logic [3:0] cwe, logic [11:0] ca,
                       logic dr, logic [3:0] dwe, logic [11:0] da, logic dl);
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = 32'h5555_5555;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = 32'hA5A5_0000; dma_lock = dl;
  endtask

  // One cycle: drive at negedge, check grants/stall just after.
  task automatic step(string name, logic cr, logic dr, logic dl,
                      logic ecg, logic edg, logic est);
    @(negedge clk);
    drive(cr, 4'h0, 12'h040, dr, 4'hF, 12'h100, dl);
    #1;
    chk({name, ".cpu_gnt"},   {31'd0, cpu_gnt},   {31'd0, ecg});
    chk({name, ".dma_gnt"},   {31'd0, dma_gnt},   {31'd0, edg});
    chk({name, ".cpu_stall"}, {31'd0, cpu_stall}, {31'd0, est});
  endtask

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[12'h010] = 32'hDEAD_BEEF;
    mem[12'h004] = 32'hAAAA_AAAA;
    ram_dout = 32'h0;

    // ---- reset state: outputs low even with both requesting ----
    rst_n = 1'b0;
    drive(1'b1, 4'h0, 12'h010, 1'b1, 4'h0, 12'h020, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rst.dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rst.ram_en",  {31'd0, ram_en},  32'd0);
    chk("rst.stall",   {31'd0, cpu_stall}, 32'd0);
    chk("rst.rdata",   rdata, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'h0, 12'h0, 1'b0, 4'h0, 12'h0, 1'b0);
    rst_n = 1'b1;

    // ---- table: single accesses, partial write, unlocked contention ----
    //            cr  cwe   ca      dr  dwe   da      dwd            dl   cg   dg   st   cv   dv   rdata
    tbl[0]  = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   0,   0,   32'h0);
    tbl[1]  = mk(1, 4'h0, 12'h010, 0, 4'h0, 12'h000, 32'h0,         0,   1,   0,   0,   0,   0,   32'h0);
    tbl[2]  = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   0,   0,   32'h0);
    tbl[3]  = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   1,   0,   32'hDEAD_BEEF);
    tbl[4]  = mk(0, 4'h0, 12'h000, 1, 4'h3, 12'h004, 32'h1234_5678, 0,   0,   1,   0,   0,   0,   32'h0);
    tbl[5]  = mk(1, 4'h0, 12'h004, 0, 4'h0, 12'h000, 32'h0,         0,   1,   0,   0,   0,   0,   32'h0);
    tbl[6]  = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   0,   0,   32'h0);
    tbl[7]  = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   1,   0,   32'hAAAA_5678);
    tbl[8]  = mk(1, 4'h0, 12'h020, 1, 4'h0, 12'h030, 32'h0,         0,  !RR,  RR,  RR,  0,   0,   32'h0);
    tbl[9]  = mk(1, 4'h0, 12'h020, 1, 4'h0, 12'h030, 32'h0,         0,   1,   0,   0,   0,   0,   32'h0);
    tbl[10] = mk(1, 4'h0, 12'h020, 1, 4'h0, 12'h030, 32'h0,         0,  !RR,  RR,  RR, !RR,  RR,
                 RR ? 32'hC0DE_0030 : 32'hC0DE_0020);
    tbl[11] = mk(1, 4'h0, 12'h020, 1, 4'h0, 12'h030, 32'h0,         0,   1,   0,   0,   1,   0,   32'hC0DE_0020);
    tbl[12] = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,  !RR,  RR,
                 RR ? 32'hC0DE_0030 : 32'hC0DE_0020);
    tbl[13] = mk(0, 4'h0, 12'h000, 0, 4'h0, 12'h000, 32'h0,         0,   0,   0,   0,   1,   0,   32'hC0DE_0020);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].cr, tbl[i].cwe, tbl[i].ca, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dl);
      dma_wdata = tbl[i].dwd;
      #1;
      chk($sformatf("vec%0d.cpu_gnt", i),    {31'd0, cpu_gnt},    {31'd0, tbl[i].ecg});
      chk($sformatf("vec%0d.dma_gnt", i),    {31'd0, dma_gnt},    {31'd0, tbl[i].edg});
      chk($sformatf("vec%0d.cpu_stall", i),  {31'd0, cpu_stall},  {31'd0, tbl[i].est});
      chk($sformatf("vec%0d.cpu_rvalid", i), {31'd0, cpu_rvalid}, {31'd0, tbl[i].ecv});
      chk($sformatf("vec%0d.dma_rvalid", i), {31'd0, dma_rvalid}, {31'd0, tbl[i].edv});
      chk($sformatf("vec%0d.ram_en", i),     {31'd0, ram_en},     {31'd0, tbl[i].ecg | tbl[i].edg});
      if (tbl[i].ecv || tbl[i].edv)
        chk($sformatf("vec%0d.rdata", i), rdata, tbl[i].erd);
    end

    // ---- locked burst: DMA starts alone, CPU joins and stays ----
    // Expected: D x8, C, D x8, C, D, D
    for (int i = 0; i < 20; i++) begin
      logic c;
      c = (i == 8) || (i == 17);
      step($sformatf("burst%0d", i), i != 0, 1'b1, 1'b1, c, !c, (i != 0) && !c);
    end

    // ---- saturation: CPU idle, count parks at MAX_BURST ----
    for (int i = 0; i < 10; i++)
      step($sformatf("sat%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sat_cpu",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("sat_back", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // ---- release: dropping lock ends the burst and clears the count ----
    step("release", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      step($sformatf("relock%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("relock_8th", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("relock_cpu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("idle",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset pulse right after a CPU read grant ----
    @(negedge clk);
    drive(1'b1, 4'h0, 12'h010, 1'b0, 4'h0, 12'h0, 1'b0);
    #1 chk("rdgrant.cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(negedge clk);
    drive(1'b1, 4'hF, 12'h200, 1'b1, 4'hF, 12'h300, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstpulse.cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rstpulse.dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rstpulse.ram_en",  {31'd0, ram_en},  32'd0);
    chk("rstpulse.stall",   {31'd0, cpu_stall}, 32'd0);
    chk("rstpulse.rdata",   rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst.cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("postrst.dma_gnt", {31'd0, dma_gnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 12'h0, 1'b0, 4'h0, 12'h0, 1'b0);
      #1 chk($sformatf("postrst%0d.cpu_rvalid", i), {31'd0, cpu_rvalid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
